alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the CPU execute stage. Single-cycle integer operations produce a registered result one cycle after issue. Iterative multiply and divide run for WIDTH+1 cycles and write an internal HI/LO register pair. A valid/ready handshake lets the pipeline stall while a long operation is in flight, and a flush input kills it on exceptions or branches.

---
 rtl/alu_mc_pkg.sv | 45 ++++
 rtl/alu_mc_mdu_iter.sv | 98 +++++++++
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared ALU operation codes, FSM state type and small decode helpers for alu_mc.
package alu_mc_pkg;

   localparam int unsigned OP_W = 5;

   localparam logic [OP_W-1:0] ALUOp_NOP   = 5'd0;
   localparam logic [OP_W-1:0] ALUOp_LUI   = 5'd1;
   localparam logic [OP_W-1:0] ALUOp_ADD   = 5'd2;
   localparam logic [OP_W-1:0] ALUOp_SUB   = 5'd3;
   localparam logic [OP_W-1:0] ALUOp_AND   = 5'd4;
   localparam logic [OP_W-1:0] ALUOp_OR    = 5'd5;
   localparam logic [OP_W-1:0] ALUOp_SLT   = 5'd6;
   localparam logic [OP_W-1:0] ALUOp_SLTU  = 5'd7;
   localparam logic [OP_W-1:0] ALUOp_ADDU  = 5'd8;
   localparam logic [OP_W-1:0] ALUOp_SUBU  = 5'd9;
   localparam logic [OP_W-1:0] ALUOp_XOR   = 5'd10;
   localparam logic [OP_W-1:0] ALUOp_NOR   = 5'd11;
   localparam logic [OP_W-1:0] ALUOp_SLL   = 5'd12;
   localparam logic [OP_W-1:0] ALUOp_SRL   = 5'd13;
   localparam logic [OP_W-1:0] ALUOp_SRA   = 5'd14;
   localparam logic [OP_W-1:0] ALUOp_EQL   = 5'd15;
   localparam logic [OP_W-1:0] ALUOp_NE    = 5'd16;
   localparam logic [OP_W-1:0] ALUOp_MULT  = 5'd17;
   localparam logic [OP_W-1:0] ALUOp_MULTU = 5'd18;
   localparam logic [OP_W-1:0] ALUOp_DIV   = 5'd19;
   localparam logic [OP_W-1:0] ALUOp_DIVU  = 5'd20;
   localparam logic [OP_W-1:0] ALUOp_MFHI  = 5'd21;
   localparam logic [OP_W-1:0] ALUOp_MFLO  = 5'd22;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DONE = 2'd1,
      S_MUL  = 2'd2,
      S_DIV  = 2'd3
   } state_t;

   function automatic logic is_mul_op(input logic [OP_W-1:0] op);
      return (op == ALUOp_MULT) || (op == ALUOp_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return (op == ALUOp_DIV) || (op == ALUOp_DIVU);
   endfunction

endpackage

// File: rtl/alu_mc_mdu_iter.sv
// Shared iterative datapath: radix-2 shift-add multiply and restoring divide.
// Results on hi/lo are valid combinationally in the cycle that done is high.
module mdu_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             kill,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] hi_q, lo_q, b_q, a_raw_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q, div_q, neg_q, neg_rem_q, div0_q;

   logic             a_neg, b_neg, ge;
   logic [WIDTH:0]   add_s;
   logic [WIDTH-1:0] rem_sh, diff, nxt_hi, nxt_lo;
   logic [2*WIDTH-1:0] prod;

   assign a_neg = is_signed && a[WIDTH-1];
   assign b_neg = is_signed && b[WIDTH-1];
   assign done  = run_q && (cnt_q == CNT_W'(WIDTH - 1));

   // One iteration step, plus sign/special-case fixup of the would-be final value
   always_comb begin
      add_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      ge     = {hi_q, lo_q[WIDTH-1]} >= {1'b0, b_q};
      diff   = rem_sh - b_q;
      if (div_q) begin
         nxt_hi = ge ? diff : rem_sh;
         nxt_lo = {lo_q[WIDTH-2:0], ge};
      end else begin
         nxt_hi = add_s[WIDTH:1];
         nxt_lo = {add_s[0], lo_q[WIDTH-1:1]};
      end
      prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
      hi   = prod[2*WIDTH-1:WIDTH];
      lo   = prod[WIDTH-1:0];
      if (div_q) begin
         if (div0_q) begin
            hi = a_raw_q;
            lo = '1;
         end else begin
            hi = neg_rem_q ? -nxt_hi : nxt_hi;
            lo = neg_q ? -nxt_lo : nxt_lo;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         a_raw_q   <= '0;
         cnt_q     <= '0;
         run_q     <= 1'b0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else if (kill) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         hi_q      <= '0;
         lo_q      <= a_neg ? -a : a;
         b_q       <= b_neg ? -b : b;
         a_raw_q   <= a;
         cnt_q     <= '0;
         run_q     <= 1'b1;
         div_q     <= is_div;
         neg_q     <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
         div0_q    <= (b == '0);
      end else if (run_q) begin
         hi_q <= nxt_hi;
         lo_q <= nxt_lo;
         if (done) begin
            run_q <= 1'b0;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle integer ops plus iterative
// multiply/divide into HI/LO, with valid/ready handshake and flush.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       ALUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       shamt,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] C,
   output logic             zero,
   output logic             ovf,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] c_q, c_d, hi_q, hi_d, lo_q, lo_d;
   logic             zero_q, zero_d, ovf_q, ovf_d, busy_q, busy_d;

   logic             op_mul, op_div, mdu_start, mdu_done;
   logic [WIDTH-1:0] mdu_hi, mdu_lo, sum, diff, alu_res;
   logic             alu_zero, alu_ovf;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE) && !flush;
   assign C         = c_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign busy      = busy_q;

   assign op_mul    = is_mul_op(ALUOp);
   assign op_div    = is_div_op(ALUOp);
   assign mdu_start = in_valid && in_ready && !flush && (op_mul || op_div);
   assign sum       = A + B;
   assign diff      = A - B;

   mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mdu (
      .clk       (clk),
      .rstn      (rstn),
      .start     (mdu_start),
      .is_div    (op_div),
      .is_signed ((ALUOp == ALUOp_MULT) || (ALUOp == ALUOp_DIV)),
      .a         (A),
      .b         (B),
      .kill      (flush),
      .done      (mdu_done),
      .hi        (mdu_hi),
      .lo        (mdu_lo)
   );

   // Single-cycle datapath; shifts operate on B (the rt operand)
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ALUOp)
         ALUOp_ADD: begin
            alu_res = sum;
            alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         ALUOp_SUB: begin
            alu_res = diff;
            alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         ALUOp_ADDU: alu_res = sum;
         ALUOp_SUBU: alu_res = diff;
         ALUOp_AND:  alu_res = A & B;
         ALUOp_OR:   alu_res = A | B;
         ALUOp_XOR:  alu_res = A ^ B;
         ALUOp_NOR:  alu_res = ~(A | B);
         ALUOp_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
         ALUOp_SLTU: alu_res = WIDTH'(A < B);
         ALUOp_LUI:  alu_res = B << 16;
         ALUOp_SLL:  alu_res = B << shamt;
         ALUOp_SRL:  alu_res = B >> shamt;
         ALUOp_SRA:  alu_res = WIDTH'($signed(B) >>> shamt);
         ALUOp_MFHI: alu_res = hi_q;
         ALUOp_MFLO: alu_res = lo_q;
         default:    alu_res = '0;
      endcase
      if (ALUOp == ALUOp_EQL)     alu_zero = (A == B);
      else if (ALUOp == ALUOp_NE) alu_zero = (A != B);
      else                        alu_zero = (alu_res == '0);
   end

   // Next-state and registered-output logic; flush overrides everything
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  if (op_mul) begin
                     state_d = S_MUL;
                     busy_d  = 1'b1;
                  end else if (op_div) begin
                     state_d = S_DIV;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = S_DONE;
                     c_d     = alu_res;
                     zero_d  = alu_zero;
                     ovf_d   = alu_ovf;
                  end
               end
            end
            S_MUL, S_DIV: begin
               busy_d = 1'b1;
               if (mdu_done) begin
                  state_d = S_DONE;
                  c_d     = mdu_lo;
                  hi_d    = mdu_hi;
                  lo_d    = mdu_lo;
                  zero_d  = (mdu_lo == '0);
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
   import alu_mc_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0, flush = 1'b0;
   logic [4:0]  ALUOp = '0, shamt = '0;
   logic [31:0] A = '0, B = '0;
   logic        in_ready, out_valid, zero, ovf, busy;
   logic [31:0] C;

   logic        in_valid8 = 1'b0, flush8 = 1'b0;
   logic [4:0]  ALUOp8 = '0, shamt8 = '0;
   logic [7:0]  A8 = '0, B8 = '0;
   logic        in_ready8, out_valid8, zero8, ovf8, busy8;
   logic [7:0]  C8;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] c;
      logic        z;
      logic        o;
   } vec_t;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .ALUOp(ALUOp), .A(A), .B(B), .shamt(shamt), .flush(flush),
      .out_valid(out_valid), .C(C), .zero(zero), .ovf(ovf), .busy(busy)
   );

   alu_mc #(.WIDTH(8)) dut8 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8),
      .ALUOp(ALUOp8), .A(A8), .B(B8), .shamt(shamt8), .flush(flush8),
      .out_valid(out_valid8), .C(C8), .zero(zero8), .ovf(ovf8), .busy(busy8)
   );

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      @(negedge clk);
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      ALUOp = op; A = a; B = b; shamt = sh; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic issue8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      for (int i = 0; i < 100 && !in_ready8; i++) @(negedge clk);
      ALUOp8 = op; A8 = a; B8 = b; shamt8 = '0; in_valid8 = 1'b1;
      @(posedge clk);
      #1 in_valid8 = 1'b0;
   endtask

   task automatic wait_done8(output int lat);
      lat = 1;
      while (!out_valid8 && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic test_reset();
      #1 rstn = 1'b0;
      #10;
      n_chk++; if ({out_valid, busy, zero, ovf} !== 4'b0) begin n_fail++;
         $display("FAIL reset_flags: got %b expected 0000", {out_valid, busy, zero, ovf}); end
      n_chk++; if (C !== 32'h0) begin n_fail++; $display("FAIL reset_c: got %h expected 0", C); end
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_add();
      int lat;
      issue(ALUOp_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
      wait_done(lat);
      n_chk++; if (lat != 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
      n_chk++; if (C !== 32'h8000_0000) begin n_fail++; $display("FAIL add_c: got %h expected 80000000", C); end
      n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL add_ovf: got %b expected 1", ovf); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL done_in_ready: got %b expected 0", in_ready); end
      issue(ALUOp_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'h8000_0000) begin n_fail++; $display("FAIL addu_c: got %h expected 80000000", C); end
      n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL addu_ovf: got %b expected 0", ovf); end
   endtask

   task automatic test_single();
      vec_t vq[$];
      int lat;
      vq.push_back('{ALUOp_SUB,  32'h8000_0000, 32'h1,     5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1});
      vq.push_back('{ALUOp_SUBU, 32'h8000_0000, 32'h1,     5'd0,  32'h7FFF_FFFF, 1'b0, 1'b0});
      vq.push_back('{ALUOp_SUB,  32'h5,         32'h5,     5'd0,  32'h0,         1'b1, 1'b0});
      vq.push_back('{ALUOp_AND,  32'hF0F0,      32'hFF00,  5'd0,  32'hF000,      1'b0, 1'b0});
      vq.push_back('{ALUOp_OR,   32'hF0F0,      32'hFF00,  5'd0,  32'hFFF0,      1'b0, 1'b0});
      vq.push_back('{ALUOp_XOR,  32'hF0F0,      32'hFF00,  5'd0,  32'h0FF0,      1'b0, 1'b0});
      vq.push_back('{ALUOp_NOR,  32'h0,         32'h0,     5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0});
      vq.push_back('{ALUOp_SLT,  32'hFFFF_FFFF, 32'h1,     5'd0,  32'h1,         1'b0, 1'b0});
      vq.push_back('{ALUOp_SLTU, 32'hFFFF_FFFF, 32'h1,     5'd0,  32'h0,         1'b1, 1'b0});
      vq.push_back('{ALUOp_LUI,  32'h0,         32'h1234,  5'd0,  32'h1234_0000, 1'b0, 1'b0});
      vq.push_back('{ALUOp_SLL,  32'h0,         32'h1,     5'd31, 32'h8000_0000, 1'b0, 1'b0});
      vq.push_back('{ALUOp_SRL,  32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0});
      vq.push_back('{ALUOp_SRA,  32'h0,         32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0});
      vq.push_back('{ALUOp_EQL,  32'h5,         32'h5,     5'd0,  32'h0,         1'b1, 1'b0});
      vq.push_back('{ALUOp_NE,   32'h5,         32'h5,     5'd0,  32'h0,         1'b0, 1'b0});
      vq.push_back('{ALUOp_NE,   32'h5,         32'h6,     5'd0,  32'h0,         1'b1, 1'b0});
      vq.push_back('{5'd31,      32'h1234,      32'h5678,  5'd0,  32'h0,         1'b1, 1'b0});
      foreach (vq[i]) begin
         issue(vq[i].op, vq[i].a, vq[i].b, vq[i].sh);
         wait_done(lat);
         n_chk++; if (lat != 1) begin n_fail++;
            $display("FAIL single_latency[%0d]: got %0d expected 1", i, lat); end
         n_chk++; if (C !== vq[i].c) begin n_fail++;
            $display("FAIL single_c[%0d] op %0d: got %h expected %h", i, vq[i].op, C, vq[i].c); end
         n_chk++; if (zero !== vq[i].z) begin n_fail++;
            $display("FAIL single_zero[%0d] op %0d: got %b expected %b", i, vq[i].op, zero, vq[i].z); end
         n_chk++; if (ovf !== vq[i].o) begin n_fail++;
            $display("FAIL single_ovf[%0d] op %0d: got %b expected %b", i, vq[i].op, ovf, vq[i].o); end
      end
   endtask

   task automatic test_mult();
      int lat;
      issue(ALUOp_MULT, 32'hFFFF_FFFD, 32'h7, 5'd0);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy: got %b expected 1", busy); end
      wait_done(lat);
      n_chk++; if (lat != 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", lat); end
      n_chk++; if (C !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_c: got %h expected ffffffeb", C); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_done: got %b expected 1", busy); end
      issue(ALUOp_MFHI, 32'h0, 32'h0, 5'd0);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_after: got %b expected 0", busy); end
      wait_done(lat);
      n_chk++; if (C !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", C); end
      issue(ALUOp_MFLO, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", C); end
   endtask

   task automatic test_div();
      int lat;
      issue(ALUOp_DIV, 32'hFFFF_FFF9, 32'h2, 5'd0);
      wait_done(lat);
      n_chk++; if (lat != 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", lat); end
      n_chk++; if (C !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", C); end
      issue(ALUOp_MFHI, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", C); end
      issue(ALUOp_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'h8000_0000) begin n_fail++; $display("FAIL divmin_lo: got %h expected 80000000", C); end
      issue(ALUOp_MFHI, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'h0) begin n_fail++; $display("FAIL divmin_hi: got %h expected 0", C); end
      issue(ALUOp_DIVU, 32'h5, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h expected ffffffff", C); end
      issue(ALUOp_MFHI, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'h5) begin n_fail++; $display("FAIL div0_hi: got %h expected 5", C); end
   endtask

   task automatic test_flush();
      int lat;
      int seen;
      issue(ALUOp_MULTU, 32'hFFFF, 32'hFFFF, 5'd0);
      repeat (4) @(posedge clk);
      @(negedge clk) flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      n_chk++; if (seen != 0) begin n_fail++; $display("FAIL flush_out_valid: got %0d pulses expected 0", seen); end
      issue(ALUOp_MFHI, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'h5) begin n_fail++; $display("FAIL flush_hi: got %h expected 5", C); end
      issue(ALUOp_MFLO, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_lo: got %h expected ffffffff", C); end
   endtask

   task automatic test_flush_idle();
      @(negedge clk);
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      ALUOp = ALUOp_ADD; A = 32'h1; B = 32'h1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready: got %b expected 1", in_ready); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_valid: got %b expected 0", out_valid); end
      n_chk++; if (C !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_idle_c: got %h expected ffffffff", C); end
   endtask

   task automatic test_reset_mid();
      int lat;
      issue(ALUOp_MULT, 32'h3, 32'h7, 5'd0);
      repeat (9) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      n_chk++; if ({out_valid, busy, zero, ovf} !== 4'b0) begin n_fail++;
         $display("FAIL rmid_flags: got %b expected 0000", {out_valid, busy, zero, ovf}); end
      n_chk++; if (C !== 32'h0) begin n_fail++; $display("FAIL rmid_c: got %h expected 0", C); end
      @(negedge clk) rstn = 1'b1;
      #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
      issue(ALUOp_MFHI, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'h0) begin n_fail++; $display("FAIL rmid_hi: got %h expected 0", C); end
      issue(ALUOp_MFLO, 32'h0, 32'h0, 5'd0);
      wait_done(lat);
      n_chk++; if (C !== 32'h0) begin n_fail++; $display("FAIL rmid_lo: got %h expected 0", C); end
   endtask

   task automatic test_width8();
      int lat;
      issue8(ALUOp_MULTU, 8'hFF, 8'hFF);
      wait_done8(lat);
      n_chk++; if (lat != 9) begin n_fail++; $display("FAIL w8_latency: got %0d expected 9", lat); end
      n_chk++; if (C8 !== 8'h01) begin n_fail++; $display("FAIL w8_lo: got %h expected 01", C8); end
      issue8(ALUOp_MFHI, 8'h0, 8'h0);
      wait_done8(lat);
      n_chk++; if (C8 !== 8'hFE) begin n_fail++; $display("FAIL w8_hi: got %h expected fe", C8); end
      issue8(ALUOp_EQL, 8'h5, 8'h5);
      wait_done8(lat);
      n_chk++; if (zero8 !== 1'b1) begin n_fail++; $display("FAIL w8_eql: got %b expected 1", zero8); end
      issue8(ALUOp_NE, 8'h5, 8'h5);
      wait_done8(lat);
      n_chk++; if (zero8 !== 1'b0) begin n_fail++; $display("FAIL w8_ne: got %b expected 0", zero8); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_single();
      test_mult();
      test_div();
      test_flush();
      test_flush_idle();
      test_reset_mid();
      test_width8();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
